// File: rtl/lsd_buffer_reader.sv
// Streams a frame's line segments out of the LSD buffer, one per beat: first beat 2 cycles after in_start.
// A stalled beat holds data and valid; dropping in_buf_ready aborts the dump after the current beat.
module lsd_buffer_reader #(
  parameter int FRAME_HEIGHT = 480,
  parameter int FRAME_WIDTH  = 640,
  parameter int RAM_SIZE     = 4096,
  localparam int V_BITW    = $clog2(FRAME_HEIGHT),
  localparam int H_BITW    = $clog2(FRAME_WIDTH),
  localparam int ADDR_BITW = $clog2(RAM_SIZE),
  localparam int WORD_SIZE = (H_BITW + V_BITW) * 2
) (
  input  logic                 clock,
  input  logic                 n_rst,
  input  logic                 in_start,
  input  logic                 in_buf_ready,
  input  logic [ADDR_BITW:0]   in_line_num,
  input  logic [WORD_SIZE-1:0] in_data,
  output logic [ADDR_BITW-1:0] out_rd_addr,
  output logic                 out_valid,
  input  logic                 in_ready,
  output logic [V_BITW-1:0]    out_start_v,
  output logic [H_BITW-1:0]    out_start_h,
  output logic [V_BITW-1:0]    out_end_v,
  output logic [H_BITW-1:0]    out_end_h,
  output logic [ADDR_BITW-1:0] out_index,
  output logic                 out_last,
  output logic                 out_busy,
  output logic                 out_done,
  output logic                 out_abort
);

  typedef enum logic [1:0] {IDLE, WAIT, STREAM, DONE} state_t;

  localparam logic [ADDR_BITW:0] RAM_DEPTH = (ADDR_BITW + 1)'(RAM_SIZE);
  localparam logic [ADDR_BITW:0] CNT_ONE   = (ADDR_BITW + 1)'(1);

  state_t               state_q;
  logic [ADDR_BITW:0]   total_q;
  logic                 abort_q;
  logic [ADDR_BITW-1:0] rd_addr_q;
  logic [ADDR_BITW-1:0] index_q;
  logic                 valid_q;
  logic                 last_q;
  logic                 busy_q;
  logic                 done_q;
  logic                 abort_pulse_q;
  logic [V_BITW-1:0]    start_v_q;
  logic [H_BITW-1:0]    start_h_q;
  logic [V_BITW-1:0]    end_v_q;
  logic [H_BITW-1:0]    end_h_q;

  logic [ADDR_BITW:0]   total_d;
  logic [ADDR_BITW:0]   index_inc;
  logic                 accept;
  logic [V_BITW-1:0]    word_sv;
  logic [H_BITW-1:0]    word_sh;
  logic [V_BITW-1:0]    word_ev;
  logic [H_BITW-1:0]    word_eh;

  // The buffer's count can exceed its depth; never read past the end.
  always_comb begin
    total_d = in_line_num;
    if (in_line_num > RAM_DEPTH) total_d = RAM_DEPTH;
  end

  assign index_inc = {1'b0, index_q} + CNT_ONE;
  assign accept    = valid_q & in_ready;
  assign {word_sv, word_sh, word_ev, word_eh} = in_data;

  always_ff @(posedge clock) begin
    if (!n_rst) begin
      state_q       <= IDLE;
      total_q       <= '0;
      abort_q       <= 1'b0;
      rd_addr_q     <= '0;
      index_q       <= '0;
      valid_q       <= 1'b0;
      last_q        <= 1'b0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      abort_pulse_q <= 1'b0;
      start_v_q     <= '0;
      start_h_q     <= '0;
      end_v_q       <= '0;
      end_h_q       <= '0;
    end else begin
      done_q        <= 1'b0;
      abort_pulse_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (in_start) begin
            state_q <= WAIT;
            busy_q  <= 1'b1;
          end
        end
        WAIT: begin
          if (in_buf_ready) begin
            total_q <= total_d;
            if (total_d == '0) begin
              state_q <= DONE;
              done_q  <= 1'b1;
            end else begin
              start_v_q <= word_sv;
              start_h_q <= word_sh;
              end_v_q   <= word_ev;
              end_h_q   <= word_eh;
              valid_q   <= 1'b1;
              index_q   <= '0;
              rd_addr_q <= ADDR_BITW'(1);
              last_q    <= (total_d == CNT_ONE);
              state_q   <= STREAM;
            end
          end
        end
        STREAM: begin
          // Losing buffer-ready means the next frame is overwriting the RAM.
          if (!in_buf_ready) abort_q <= 1'b1;
          if (accept) begin
            if (last_q || !in_buf_ready) begin
              valid_q       <= 1'b0;
              state_q       <= DONE;
              done_q        <= 1'b1;
              abort_pulse_q <= abort_q | ~in_buf_ready;
            end else begin
              start_v_q <= word_sv;
              start_h_q <= word_sh;
              end_v_q   <= word_ev;
              end_h_q   <= word_eh;
              index_q   <= index_q + ADDR_BITW'(1);
              rd_addr_q <= rd_addr_q + ADDR_BITW'(1);
              last_q    <= (index_inc == total_q - CNT_ONE);
            end
          end else if (!in_buf_ready) begin
            last_q <= 1'b1;
          end
        end
        DONE: begin
          state_q   <= IDLE;
          busy_q    <= 1'b0;
          abort_q   <= 1'b0;
          rd_addr_q <= '0;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign out_rd_addr = rd_addr_q;
  assign out_valid   = valid_q;
  assign out_start_v = start_v_q;
  assign out_start_h = start_h_q;
  assign out_end_v   = end_v_q;
  assign out_end_h   = end_h_q;
  assign out_index   = index_q;
  assign out_last    = last_q;
  assign out_busy    = busy_q;
  assign out_done    = done_q;
  assign out_abort   = abort_pulse_q;

endmodule

// File: tb/tb_lsd_buffer_reader.sv
// Scoreboarded bench for lsd_buffer_reader: random segment RAM and line counts, random/pattern backpressure, abort and reset.
module tb_lsd_buffer_reader;
  localparam int RS = 16;
  localparam int VB = 4;
  localparam int HB = 5;
  localparam int AB = 4;
  localparam int WS = 18;

  logic          clock = 1'b0;
  logic          n_rst;
  logic          in_start;
  logic          in_buf_ready;
  logic          in_ready;
  logic [AB:0]   in_line_num;
  logic [WS-1:0] in_data;
  logic [AB-1:0] out_rd_addr;
  logic [AB-1:0] out_index;
  logic          out_valid, out_last, out_busy, out_done, out_abort;
  logic [VB-1:0] out_start_v, out_end_v;
  logic [HB-1:0] out_start_h, out_end_h;

  logic [WS-1:0] mem [RS];
  int total_cnt = 0;
  int bad_cnt   = 0;

  typedef struct {
    int            idx;
    logic [WS-1:0] word;
    bit            last;
  } beat_t;

  beat_t exp_q[$];
  bit    done_q[$];

  logic          held = 1'b0;
  logic [21:0]   held_dat;

  always #5 clock = ~clock;

  assign in_data = mem[out_rd_addr];

  lsd_buffer_reader #(
    .FRAME_HEIGHT(16),
    .FRAME_WIDTH (32),
    .RAM_SIZE    (RS)
  ) dut (
    .clock       (clock),
    .n_rst       (n_rst),
    .in_start    (in_start),
    .in_buf_ready(in_buf_ready),
    .in_line_num (in_line_num),
    .in_data     (in_data),
    .out_rd_addr (out_rd_addr),
    .out_valid   (out_valid),
    .in_ready    (in_ready),
    .out_start_v (out_start_v),
    .out_start_h (out_start_h),
    .out_end_v   (out_end_v),
    .out_end_h   (out_end_h),
    .out_index   (out_index),
    .out_last    (out_last),
    .out_busy    (out_busy),
    .out_done    (out_done),
    .out_abort   (out_abort)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act !== exp) begin
      bad_cnt++;
      $display("FAIL %s: got %0h, required %0h", name, act, exp);
    end
  endtask

  task automatic flag(input string name);
    total_cnt++;
    bad_cnt++;
    $display("FAIL %s: bound expired", name);
  endtask

  // Monitor: pops expectations whenever the DUT hands over a beat or a done pulse.
  always @(negedge clock) begin
    logic [21:0] cur;
    beat_t       b;
    cur = {out_index, out_start_v, out_start_h, out_end_v, out_end_h};
    if (!n_rst) begin
      held = 1'b0;
    end else begin
      if (out_valid) begin
        if (held) check("stall_stable", 32'(cur), 32'(held_dat));
        if (in_ready) begin
          held = 1'b0;
          if (exp_q.size() == 0) begin
            total_cnt++;
            bad_cnt++;
            $display("FAIL unexpected_beat: got index %0d, required no beat", out_index);
          end else begin
            b = exp_q.pop_front();
            check("beat_data", 32'(cur), 32'({4'(b.idx), b.word}));
            check("beat_last", 32'(out_last), 32'(b.last));
          end
        end else begin
          held     = 1'b1;
          held_dat = cur;
        end
      end else if (held) begin
        check("valid_held", 32'(out_valid), 32'(1));
        held = 1'b0;
      end
      if (out_done) begin
        if (done_q.size() == 0) begin
          total_cnt++;
          bad_cnt++;
          $display("FAIL unexpected_done: got done, required none");
        end else begin
          check("done_abort", 32'(out_abort), 32'(done_q.pop_front()));
        end
      end else if (out_abort) begin
        total_cnt++;
        bad_cnt++;
        $display("FAIL stray_abort: got abort=1 without done, required 0");
      end
    end
  end

  task automatic check_zero(input string tag);
    check({tag, "_ctrl"}, 32'({out_rd_addr, out_valid, out_last, out_busy, out_done, out_abort, out_index}), 32'(0));
    check({tag, "_data"}, 32'({out_start_v, out_start_h, out_end_v, out_end_h}), 32'(0));
  endtask

  task automatic fill_mem();
    for (int i = 0; i < RS; i++) mem[i] = WS'($urandom);
  endtask

  // mode: 0 = always ready, 1 = ready pattern 1,0,0 repeating, 2 = random ready
  task automatic run_frame(input int line_num, input int mode, input int ready_delay);
    int tot;
    bit got;
    fill_mem();
    tot = (line_num > RS) ? RS : line_num;
    for (int i = 0; i < tot; i++) exp_q.push_back('{i, mem[i], (i == tot - 1)});
    done_q.push_back(1'b0);
    in_line_num  = (AB + 1)'(line_num);
    in_buf_ready = (ready_delay == 0);
    in_ready     = 1'b0;
    in_start     = 1'b1;
    @(posedge clock); #1;
    in_start = 1'b0;
    check("busy_after_start", 32'(out_busy), 32'(1));
    for (int d = 0; d < ready_delay; d++) begin
      in_start = (d == 2);
      @(posedge clock); #1;
      check("no_valid_before_ready", 32'(out_valid), 32'(0));
    end
    in_start     = 1'b0;
    in_buf_ready = 1'b1;
    got = 1'b0;
    for (int c = 1; c <= 300 && !got; c++) begin
      if (mode == 0)      in_ready = 1'b1;
      else if (mode == 1) in_ready = (c % 3 == 1);
      else                in_ready = 1'($urandom_range(0, 1));
      @(posedge clock); #1;
      if (c == 1) check("valid_after_ready", 32'(out_valid), 32'(tot > 0));
      if (tot == RS && out_valid && out_index == AB'(RS - 1))
        check("rd_addr_wrap", 32'(out_rd_addr), 32'(0));
      if (out_done) begin
        got = 1'b1;
        if (mode == 0) check("done_cycle", c, (tot == 0) ? 1 : tot + 1);
      end
    end
    if (!got) flag("done_timeout");
    in_ready = 1'b0;
    @(posedge clock); #1;
    check("busy_fall", 32'({out_busy, out_done, out_valid}), 32'(0));
    check("idle_rd_addr", 32'(out_rd_addr), 32'(0));
  endtask

  task automatic run_abort();
    bit seen;
    fill_mem();
    for (int i = 0; i < 4; i++) exp_q.push_back('{i, mem[i], (i == 3)});
    done_q.push_back(1'b1);
    in_line_num  = (AB + 1)'(8);
    in_buf_ready = 1'b1;
    in_ready     = 1'b1;
    in_start     = 1'b1;
    @(posedge clock); #1;
    in_start = 1'b0;
    seen = 1'b0;
    for (int c = 0; c < 50 && !seen; c++) begin
      @(posedge clock); #1;
      if (out_valid && out_index == AB'(3)) seen = 1'b1;
    end
    if (!seen) flag("abort_beat3_timeout");
    in_ready = 1'b0;
    repeat (2) @(posedge clock);
    #1;
    check("abort_pre_last", 32'(out_last), 32'(0));
    in_buf_ready = 1'b0;
    @(posedge clock); #1;
    check("abort_held", 32'({out_valid, out_index, out_done}), 32'({1'b1, 4'd3, 1'b0}));
    check("abort_forced_last", 32'(out_last), 32'(1));
    @(posedge clock); #1;
    in_ready = 1'b1;
    @(posedge clock); #1;
    check("abort_done", 32'({out_done, out_abort, out_valid}), 32'(3'b110));
    in_ready     = 1'b0;
    in_buf_ready = 1'b1;
    @(posedge clock); #1;
    check("abort_busy_fall", 32'(out_busy), 32'(0));
    in_ready = 1'b1;
    repeat (3) @(posedge clock);
    #1;
    check("abort_no_beat4", 32'({out_valid, out_busy}), 32'(0));
    in_ready = 1'b0;
  endtask

  task automatic run_reset_mid();
    fill_mem();
    for (int i = 0; i < RS; i++) exp_q.push_back('{i, mem[i], (i == RS - 1)});
    in_line_num  = (AB + 1)'(RS);
    in_buf_ready = 1'b1;
    in_ready     = 1'b1;
    in_start     = 1'b1;
    @(posedge clock); #1;
    in_start = 1'b0;
    repeat (6) @(posedge clock);
    #1;
    check("pre_reset_streaming", 32'(out_valid), 32'(1));
    n_rst = 1'b0;
    @(posedge clock); #1;
    check_zero("mid_reset");
    exp_q.delete();
    done_q.delete();
    n_rst    = 1'b1;
    in_ready = 1'b0;
    @(posedge clock); #1;
    check("post_reset_quiet", 32'({out_done, out_busy, out_valid}), 32'(0));
  endtask

  initial begin
    n_rst        = 1'b0;
    in_start     = 1'b0;
    in_buf_ready = 1'b0;
    in_ready     = 1'b0;
    in_line_num  = '0;
    for (int i = 0; i < RS; i++) mem[i] = '0;
    repeat (3) @(posedge clock);
    #1;
    check_zero("reset");
    n_rst = 1'b1;
    @(posedge clock); #1;

    run_frame(3, 0, 0);
    run_frame(5, 1, 0);
    run_frame(0, 0, 0);
    run_frame(4, 0, 10);
    run_abort();
    run_frame(16, 2, 0);
    run_frame(16, 0, 0);
    run_frame(20, 1, 0);
    run_frame(1, 0, 0);
    for (int k = 0; k < 12; k++)
      run_frame(int'($urandom_range(0, 31)), int'($urandom_range(0, 2)), int'($urandom_range(0, 3)));
    run_reset_mid();
    run_frame(2, 0, 0);

    check("leftover_beats", 32'(exp_q.size()), 32'(0));
    check("leftover_done", 32'(done_q.size()), 32'(0));
    $display("test done: total=%0d bad=%0d", total_cnt, bad_cnt);
    $finish;
  end

endmodule
